fetch_pc_reader: RTL and testbench
==================================

Name: fetch_pc_reader

Overview:
- Consumer side of the per-wavefront PC store. Each fetch cycle it selects one eligible wavefront round-robin and issues the PC read/advance strobe to the PC store.
- It captures the returned {first_flag, pc} and issues a single-outstanding instruction-memory request.
- It hands the fetched instruction, tagged with wavefront id and PC, to the instruction buffer.
- It sits between the wavepool/ibuffer eligibility logic, the PC store and the instruction memory port.

Parameters:
- NUM_WF, 40, number of wavefront slots (ids 0..NUM_WF-1).
- WF_ID_W, 6, width of wavefront id.
- PC_W, 32, PC and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wf_fetch_ok  in  NUM_WF  per-wavefront eligibility (active and ibuffer has space)
- pc_wr  in  1  PC store write strobe (new/branch PC), snooped for squash
- pc_wr_wfid  in  WF_ID_W  wavefront id of that write
- pc_rd_en  out  1  one-cycle PC read/advance strobe to PC store
- pc_rd_wfid  out  WF_ID_W  wavefront id being read
- pc_rd_data  in  PC_W+1  {first_flag, pc}, combinational from PC store for pc_rd_wfid
- mem_req  out  1  instruction fetch request, level, held until ack
- mem_addr  out  PC_W  fetch address
- mem_ack  in  1  one-cycle acknowledge, data valid same cycle
- mem_rdata  in  PC_W  instruction word
- ibuf_valid  out  1  one-cycle instruction delivery pulse
- ibuf_wfid  out  WF_ID_W  wavefront id of delivered instruction
- ibuf_pc  out  PC_W  PC of delivered instruction
- ibuf_instr  out  PC_W  instruction word
- ibuf_first  out  1  first fetch after PC (re)initialisation

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; round-robin pointer=NUM_WF-1, so wf 0 has first priority; squash=0. All outputs 0: pc_rd_en, pc_rd_wfid, mem_req, mem_addr, ibuf_*.
- FSM has three states:
  - IDLE: if any wf_fetch_ok bit is set, grant the first set bit searching from ptr+1 upward with wrap NUM_WF-1 -> 0. In that same cycle assert pc_rd_en=1 with pc_rd_wfid=grant (combinational). At the edge, latch pc_rd_data[PC_W-1:0] into addr, pc_rd_data[PC_W] into first, and grant into the wfid register; set ptr=grant; go to REQ. If no bit is set, stay in IDLE with pc_rd_en=0.
  - REQ: mem_req=1 and mem_addr=latched addr, both stable until mem_ack. On mem_ack, latch mem_rdata and go to RESP. mem_ack seen in IDLE or RESP is ignored.
  - RESP: ibuf_valid=1 for exactly one cycle, unless squash=1. ibuf_wfid, ibuf_pc, ibuf_instr and ibuf_first are valid with it. Go to IDLE and clear squash.
- pc_rd_en is asserted only in IDLE, so at most one read per fetch. Minimum turnaround is 3 cycles (IDLE, REQ with same-cycle ack, RESP).
- Latency from the grant cycle to ibuf_valid is 2 cycles plus any mem_ack wait cycles.
- Squash rule: in REQ or RESP, a pc_wr with pc_wr_wfid equal to the in-flight wfid sets squash. The fetch still completes on the memory side, but ibuf_valid is suppressed.
- A pc_wr to the granted wfid in the grant cycle itself also sets squash. The PC store gives the write priority, so the read data is stale.
- Pointer wrap: after granting wf NUM_WF-1, the search restarts at 0.
- A single eligible wavefront is granted back-to-back.
- wf_fetch_ok is sampled only in IDLE. If it drops mid-fetch, the fetch still completes and delivers, unless squashed.
- rst asserted in REQ returns to IDLE with mem_req=0 on the next edge; the outstanding ack is ignored.
- Grant ids are always below NUM_WF; ids NUM_WF..63 are never driven.

Decomposition:
- Shared package fetch_pkg holds the NUM_WF, WF_ID_W and PC_W constants and the FSM state enum {IDLE, REQ, RESP}.
- One sub-module, fetch_rr_arb: combinational NUM_WF-wide round-robin priority search. Inputs are the request mask and the pointer; outputs are grant_valid and grant_id.
- The pointer register and the FSM live in fetch_pc_reader.

Test Plan:
- Reset, then wf_fetch_ok bit 0 set, pc_rd_data={1,0x100}, ack 1 cycle after mem_req -> pc_rd_en pulse with wfid 0; mem_addr=0x100; ibuf_valid with wfid=0, pc=0x100, first=1, instr=mem_rdata.
- wf_fetch_ok bits 3, 7 and 39 all set and held; ack immediate -> grant order 3, 7, 39, 3 (wrap), one ibuf_valid every 3 cycles.
- mem_ack delayed 5 cycles -> mem_req and mem_addr stable for all 5 cycles; exactly one ibuf_valid; no second pc_rd_en.
- pc_wr with pc_wr_wfid=7 while wf 7 is in REQ -> no ibuf_valid for that fetch; next IDLE grants the next eligible wf.
- pc_wr with pc_wr_wfid=12 (not in flight) while wf 7 is in REQ -> delivery of wf 7 unaffected.
- rst asserted in REQ, then a stray mem_ack -> all outputs 0, state IDLE, ptr=NUM_WF-1, no ibuf_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and FSM state encoding for the fetch-side
//               PC reader (wavefront count, id width, PC/instruction width).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Number of wavefront slots; ids run 0..NUM_WF-1.
    localparam int NUM_WF  = 40;
    // Width of a wavefront id (enough for ids up to 63).
    localparam int WF_ID_W = 6;
    // PC and instruction word width.
    localparam int PC_W    = 32;

    // Fetch FSM encoding: IDLE selects and reads a PC, REQ waits on the
    // instruction memory, RESP hands the instruction to the ibuffer.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fetch_rr_arb
// Description : Combinational NUM_WF-wide round-robin priority search. The
//               search starts at i_ptr+1 and wraps from NUM_WF-1 back to 0,
//               so the most recently granted wavefront has lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_rr_arb
    import fetch_pkg::*;
(
    input  logic [NUM_WF-1:0]  i_req,
    input  logic [WF_ID_W-1:0] i_ptr,
    output logic               o_grant_valid,
    output logic [WF_ID_W-1:0] o_grant_id
);

    // One bit wider than an id so that ptr + offset (< 2*NUM_WF) never overflows.
    logic [WF_ID_W:0]   w_sum;
    logic [WF_ID_W-1:0] w_idx;

    // Priority search: offsets are walked from farthest to nearest so the
    // last hit written (the nearest set bit after the pointer) wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = '0;
        w_sum         = '0;
        w_idx         = '0;
        for (int i = NUM_WF; i >= 1; i--) begin
            w_sum = {1'b0, i_ptr} + (WF_ID_W+1)'(i);
            if (w_sum >= (WF_ID_W+1)'(NUM_WF)) begin
                w_sum = w_sum - (WF_ID_W+1)'(NUM_WF);
            end
            w_idx = w_sum[WF_ID_W-1:0];
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_id    = w_idx;
            end
        end
    end

endmodule : fetch_rr_arb
`default_nettype wire

// File: rtl/fetch_pc_reader.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reader
// Description : Consumer side of the per-wavefront PC store. Picks one
//               eligible wavefront round-robin, reads/advances its PC,
//               issues a single-outstanding instruction fetch and delivers
//               the tagged instruction to the instruction buffer. A PC write
//               to the in-flight wavefront squashes the delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reader
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    // Eligibility from wavepool / ibuffer
    input  logic [NUM_WF-1:0]  wf_fetch_ok,
    // Snooped PC store write port
    input  logic               pc_wr,
    input  logic [WF_ID_W-1:0] pc_wr_wfid,
    // PC store read port
    output logic               pc_rd_en,
    output logic [WF_ID_W-1:0] pc_rd_wfid,
    input  logic [PC_W:0]      pc_rd_data,
    // Instruction memory port
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [PC_W-1:0]    mem_rdata,
    // Instruction buffer delivery
    output logic               ibuf_valid,
    output logic [WF_ID_W-1:0] ibuf_wfid,
    output logic [PC_W-1:0]    ibuf_pc,
    output logic [PC_W-1:0]    ibuf_instr,
    output logic               ibuf_first
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [WF_ID_W-1:0] r_ptr;     // last granted wavefront
    logic [WF_ID_W-1:0] r_wfid;    // wavefront currently in flight
    logic [PC_W-1:0]    r_addr;    // PC captured from the PC store
    logic               r_first;   // first-fetch flag captured with the PC
    logic [PC_W-1:0]    r_instr;   // instruction word returned by memory
    logic               r_squash;  // in-flight fetch made stale by a PC write

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic               w_grant_valid;
    logic [WF_ID_W-1:0] w_grant_id;
    logic               w_idle;
    logic               w_issue;
    logic               w_wr_hit_grant;
    logic               w_wr_hit_inflight;

    fetch_rr_arb u_rr_arb (
        .i_req         (wf_fetch_ok),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign w_idle  = (r_state == c_st_idle);
    // Reads are held off while reset is asserted so nothing leaks out of
    // the PC store before the FSM is known to be in IDLE.
    assign w_issue = w_idle && w_grant_valid && !rst;

    // The PC store lets a write win over a same-cycle read, so a write to
    // the wavefront being granted means the captured PC is already stale.
    assign w_wr_hit_grant    = pc_wr && (pc_wr_wfid == w_grant_id);
    assign w_wr_hit_inflight = pc_wr && (pc_wr_wfid == r_wfid);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_rd_en   = w_issue;
    assign pc_rd_wfid = w_issue ? w_grant_id : '0;

    assign mem_req    = (r_state == c_st_req);
    assign mem_addr   = mem_req ? r_addr : '0;

    // A write landing in the RESP cycle itself also kills the delivery;
    // the registered squash flag only covers writes seen earlier.
    assign ibuf_valid = (r_state == c_st_resp) && !r_squash && !w_wr_hit_inflight;
    assign ibuf_wfid  = r_wfid;
    assign ibuf_pc    = r_addr;
    assign ibuf_instr = r_instr;
    assign ibuf_first = r_first;

    // ------------------------------------------------------------------
    // Fetch FSM, round-robin pointer and fetch context capture
    // ------------------------------------------------------------------
    // Sequence one fetch at a time: grant+read, memory request, delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_ptr    <= WF_ID_W'(NUM_WF - 1);
            r_wfid   <= '0;
            r_addr   <= '0;
            r_first  <= 1'b0;
            r_instr  <= '0;
            r_squash <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_grant_valid) begin
                        r_addr   <= pc_rd_data[PC_W-1:0];
                        r_first  <= pc_rd_data[PC_W];
                        r_wfid   <= w_grant_id;
                        r_ptr    <= w_grant_id;
                        r_squash <= w_wr_hit_grant;
                        r_state  <= c_st_req;
                    end
                end

                c_st_req: begin
                    if (w_wr_hit_inflight) begin
                        r_squash <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_instr <= mem_rdata;
                        r_state <= c_st_resp;
                    end
                end

                c_st_resp: begin
                    r_squash <= 1'b0;
                    r_state  <= c_st_idle;
                end

                default: begin
                    r_squash <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

endmodule : fetch_pc_reader
`default_nettype wire

// File: tb/tb_fetch_pc_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_reader
// Description : Directed self-checking bench for fetch_pc_reader. The PC
//               store is modelled as pc = 0x100 + 16*wfid, first = (wfid<8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_reader;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_WF-1:0]  wf_fetch_ok;
    logic               pc_wr;
    logic [WF_ID_W-1:0] pc_wr_wfid;
    logic               pc_rd_en;
    logic [WF_ID_W-1:0] pc_rd_wfid;
    logic [PC_W:0]      pc_rd_data;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [PC_W-1:0]    mem_rdata;
    logic               ibuf_valid;
    logic [WF_ID_W-1:0] ibuf_wfid;
    logic [PC_W-1:0]    ibuf_pc;
    logic [PC_W-1:0]    ibuf_instr;
    logic               ibuf_first;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // PC store model: combinational read of the addressed wavefront.
    assign pc_rd_data = {(pc_rd_wfid < 6'd8), 32'h100 + {22'd0, pc_rd_wfid, 4'd0}};

    fetch_pc_reader dut (
        .clk         (clk),
        .rst         (rst),
        .wf_fetch_ok (wf_fetch_ok),
        .pc_wr       (pc_wr),
        .pc_wr_wfid  (pc_wr_wfid),
        .pc_rd_en    (pc_rd_en),
        .pc_rd_wfid  (pc_rd_wfid),
        .pc_rd_data  (pc_rd_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ibuf_valid  (ibuf_valid),
        .ibuf_wfid   (ibuf_wfid),
        .ibuf_pc     (ibuf_pc),
        .ibuf_instr  (ibuf_instr),
        .ibuf_first  (ibuf_first)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wf_fetch_ok = '0; pc_wr = 1'b0; pc_wr_wfid = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick(); #1;
        total++; if (pc_rd_en !== 1'b0) begin bad++; $display("FAIL reset_pc_rd_en: got %0h want 0", pc_rd_en); end
        total++; if (pc_rd_wfid !== 6'd0) begin bad++; $display("FAIL reset_pc_rd_wfid: got %0h want 0", pc_rd_wfid); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        total++; if (ibuf_valid !== 1'b0) begin bad++; $display("FAIL reset_ibuf_valid: got %0h want 0", ibuf_valid); end
        total++; if ({ibuf_wfid, ibuf_pc, ibuf_instr, ibuf_first} !== '0) begin
            bad++; $display("FAIL reset_ibuf_fields: got %0h/%0h/%0h/%0h want all 0", ibuf_wfid, ibuf_pc, ibuf_instr, ibuf_first);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        wf_fetch_ok = 40'h1; #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd0) begin bad++; $display("FAIL single_grant: got en=%0h id=%0d want en=1 id=0", pc_rd_en, pc_rd_wfid); end
        tick(); wf_fetch_ok = '0; #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL single_req: got req=%0h addr=%0h want 1/100", mem_req, mem_addr); end
        total++; if (pc_rd_en !== 1'b0) begin bad++; $display("FAIL single_no_reread: got %0h want 0", pc_rd_en); end
        tick(); mem_ack = 1'b1; mem_rdata = 32'hAABBCCDD; #1;
        total++; if (mem_req !== 1'b1 || ibuf_valid !== 1'b0) begin bad++; $display("FAIL single_wait: got req=%0h valid=%0h want 1/0", mem_req, ibuf_valid); end
        tick(); mem_ack = 1'b0; #1;
        total++; if (ibuf_valid !== 1'b1 || ibuf_wfid !== 6'd0 || ibuf_pc !== 32'h100 || ibuf_first !== 1'b1 || ibuf_instr !== 32'hAABBCCDD) begin
            bad++; $display("FAIL single_deliver: got v=%0h id=%0d pc=%0h f=%0h i=%0h want 1/0/100/1/aabbccdd", ibuf_valid, ibuf_wfid, ibuf_pc, ibuf_first, ibuf_instr);
        end
        tick(); #1;
        total++; if (ibuf_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL single_pulse: got valid=%0h req=%0h want 0/0", ibuf_valid, mem_req); end
    endtask

    task automatic test_round_robin();
        logic [WF_ID_W-1:0] exp_id   [4] = '{6'd3, 6'd7, 6'd39, 6'd3};
        logic [PC_W-1:0]    exp_pc   [4] = '{32'h130, 32'h170, 32'h370, 32'h130};
        logic               exp_first[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        wf_fetch_ok = '0;
        wf_fetch_ok[3] = 1'b1; wf_fetch_ok[7] = 1'b1; wf_fetch_ok[39] = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== exp_id[k]) begin bad++; $display("FAIL rr_grant%0d: got en=%0h id=%0d want en=1 id=%0d", k, pc_rd_en, pc_rd_wfid, exp_id[k]); end
            tick(); #1;
            total++; if (mem_req !== 1'b1 || mem_addr !== exp_pc[k]) begin bad++; $display("FAIL rr_req%0d: got req=%0h addr=%0h want 1/%0h", k, mem_req, mem_addr, exp_pc[k]); end
            tick(); #1;
            total++; if (ibuf_valid !== 1'b1 || ibuf_wfid !== exp_id[k] || ibuf_pc !== exp_pc[k] || ibuf_first !== exp_first[k] || ibuf_instr !== 32'h12345678) begin
                bad++; $display("FAIL rr_deliver%0d: got v=%0h id=%0d pc=%0h f=%0h i=%0h want 1/%0d/%0h/%0h/12345678", k, ibuf_valid, ibuf_wfid, ibuf_pc, ibuf_first, ibuf_instr, exp_id[k], exp_pc[k], exp_first[k]);
            end
            if (k == 3) begin wf_fetch_ok = '0; mem_ack = 1'b0; end
            tick();
        end
    endtask

    task automatic test_delayed_ack();
        int pulses = 0;
        wf_fetch_ok = '0; wf_fetch_ok[5] = 1'b1; #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd5) begin bad++; $display("FAIL delay_grant: got en=%0h id=%0d want 1/5", pc_rd_en, pc_rd_wfid); end
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'h150 || pc_rd_en !== 1'b0 || ibuf_valid !== 1'b0) begin
                bad++; $display("FAIL delay_wait%0d: got req=%0h addr=%0h rd=%0h v=%0h want 1/150/0/0", c, mem_req, mem_addr, pc_rd_en, ibuf_valid);
            end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick(); mem_ack = 1'b0; #1;
        if (ibuf_valid === 1'b1) pulses++;
        total++; if (ibuf_valid !== 1'b1 || ibuf_instr !== 32'hCAFEF00D || ibuf_wfid !== 6'd5) begin
            bad++; $display("FAIL delay_deliver: got v=%0h id=%0d i=%0h want 1/5/cafef00d", ibuf_valid, ibuf_wfid, ibuf_instr);
        end
        wf_fetch_ok = '0;
        tick(); #1;
        if (ibuf_valid === 1'b1) pulses++;
        total++; if (pulses !== 1 || pc_rd_en !== 1'b0) begin bad++; $display("FAIL delay_once: got pulses=%0d rd=%0h want 1/0", pulses, pc_rd_en); end
    endtask

    task automatic test_back_to_back();
        wf_fetch_ok = '0; wf_fetch_ok[5] = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BADCAFE;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd5) begin bad++; $display("FAIL b2b_grant%0d: got en=%0h id=%0d want 1/5", k, pc_rd_en, pc_rd_wfid); end
            tick(); tick(); #1;
            total++; if (ibuf_valid !== 1'b1 || ibuf_wfid !== 6'd5 || ibuf_pc !== 32'h150) begin bad++; $display("FAIL b2b_deliver%0d: got v=%0h id=%0d pc=%0h want 1/5/150", k, ibuf_valid, ibuf_wfid, ibuf_pc); end
            if (k == 1) begin wf_fetch_ok = '0; mem_ack = 1'b0; end
            tick();
        end
    endtask

    task automatic test_squash_inflight();
        wf_fetch_ok = '0; wf_fetch_ok[7] = 1'b1; wf_fetch_ok[9] = 1'b1; #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd7) begin bad++; $display("FAIL sq_grant: got en=%0h id=%0d want 1/7", pc_rd_en, pc_rd_wfid); end
        tick(); pc_wr = 1'b1; pc_wr_wfid = 6'd7; mem_ack = 1'b1; mem_rdata = 32'h77777777; #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h170) begin bad++; $display("FAIL sq_req: got req=%0h addr=%0h want 1/170", mem_req, mem_addr); end
        tick(); pc_wr = 1'b0; pc_wr_wfid = '0; #1;
        total++; if (ibuf_valid !== 1'b0) begin bad++; $display("FAIL sq_suppress: got %0h want 0", ibuf_valid); end
        tick(); #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd9) begin bad++; $display("FAIL sq_next_grant: got en=%0h id=%0d want 1/9", pc_rd_en, pc_rd_wfid); end
        tick(); tick(); #1;
        total++; if (ibuf_valid !== 1'b1 || ibuf_wfid !== 6'd9 || ibuf_pc !== 32'h190 || ibuf_first !== 1'b0) begin
            bad++; $display("FAIL sq_next_deliver: got v=%0h id=%0d pc=%0h f=%0h want 1/9/190/0", ibuf_valid, ibuf_wfid, ibuf_pc, ibuf_first);
        end
        wf_fetch_ok = '0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_squash_other();
        wf_fetch_ok = '0; wf_fetch_ok[7] = 1'b1; #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd7) begin bad++; $display("FAIL other_grant: got en=%0h id=%0d want 1/7", pc_rd_en, pc_rd_wfid); end
        tick(); pc_wr = 1'b1; pc_wr_wfid = 6'd12; mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
        tick(); pc_wr = 1'b0; pc_wr_wfid = '0; mem_ack = 1'b0; #1;
        total++; if (ibuf_valid !== 1'b1 || ibuf_wfid !== 6'd7 || ibuf_pc !== 32'h170 || ibuf_first !== 1'b1 || ibuf_instr !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL other_deliver: got v=%0h id=%0d pc=%0h f=%0h i=%0h want 1/7/170/1/5a5a5a5a", ibuf_valid, ibuf_wfid, ibuf_pc, ibuf_first, ibuf_instr);
        end
        wf_fetch_ok = '0;
        tick();
    endtask

    task automatic test_grant_cycle_squash();
        // Pointer is 7, so wf 2 is reached only through the wrap.
        wf_fetch_ok = '0; wf_fetch_ok[2] = 1'b1; pc_wr = 1'b1; pc_wr_wfid = 6'd2; #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd2) begin bad++; $display("FAIL gsq_grant: got en=%0h id=%0d want 1/2", pc_rd_en, pc_rd_wfid); end
        tick(); pc_wr = 1'b0; pc_wr_wfid = '0; wf_fetch_ok = '0; mem_ack = 1'b1; mem_rdata = 32'h22222222;
        tick(); mem_ack = 1'b0; #1;
        total++; if (ibuf_valid !== 1'b0) begin bad++; $display("FAIL gsq_suppress: got %0h want 0", ibuf_valid); end
        tick(); #1;
        total++; if (ibuf_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL gsq_idle: got v=%0h req=%0h want 0/0", ibuf_valid, mem_req); end
    endtask

    task automatic test_reset_in_req();
        wf_fetch_ok = '0; wf_fetch_ok[20] = 1'b1; #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd20) begin bad++; $display("FAIL rreq_grant: got en=%0h id=%0d want 1/20", pc_rd_en, pc_rd_wfid); end
        tick(); wf_fetch_ok = '0; #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h240) begin bad++; $display("FAIL rreq_req: got req=%0h addr=%0h want 1/240", mem_req, mem_addr); end
        rst = 1'b1;
        tick(); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || pc_rd_en !== 1'b0 || ibuf_valid !== 1'b0) begin
            bad++; $display("FAIL rreq_cleared: got req=%0h addr=%0h rd=%0h v=%0h want 0/0/0/0", mem_req, mem_addr, pc_rd_en, ibuf_valid);
        end
        tick(); mem_ack = 1'b0; #1;
        total++; if (ibuf_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rreq_stray_ack: got v=%0h req=%0h want 0/0", ibuf_valid, mem_req); end
        // Pointer back at NUM_WF-1 means wf 0 outranks wf 25.
        wf_fetch_ok[0] = 1'b1; wf_fetch_ok[25] = 1'b1; #1;
        total++; if (pc_rd_en !== 1'b1 || pc_rd_wfid !== 6'd0) begin bad++; $display("FAIL rreq_ptr: got en=%0h id=%0d want 1/0", pc_rd_en, pc_rd_wfid); end
        wf_fetch_ok = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_delayed_ack();
        test_back_to_back();
        test_squash_inflight();
        test_squash_other();
        test_grant_cycle_squash();
        test_reset_in_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_pc_reader
`default_nettype wire
